// File: rtl/change_return_controller_pkg.sv
// Shared constants and state encoding for the vending machine change-return path.
package change_return_controller_pkg;

    localparam int unsigned kNumCoins  = 3;
    localparam int unsigned kNumItems  = 2;
    localparam int unsigned kTotalBits = 31;
    localparam int unsigned kWaitTime  = 10;

    typedef enum logic [1:0] {
        kStateIdle   = 2'd0,
        kStateActive = 2'd1,
        kStateReturn = 2'd2
    } state_e;

endpackage

// File: rtl/change_return_controller_coin_picker.sv
// Greedy largest-first coin selection for one refund cycle.
// CHANGE_BATCH_EN: when defined, every denomination that still fits is taken in the
// same cycle (multi-hot mask); otherwise only the largest fitting coin (one-hot).
module coin_picker #(
    parameter int unsigned NUM_COINS  = 3,
    parameter int unsigned TOTAL_BITS = 31
) (
    input  logic [TOTAL_BITS-1:0]     current_total,
    input  logic [NUM_COINS-1:0][31:0] coin_value,
    output logic [NUM_COINS-1:0]      coin_mask,
    output logic [TOTAL_BITS-1:0]     coin_sum
);

    logic [31:0] total_ext;
    logic [31:0] remaining;
    logic        found;

    assign total_ext = 32'(current_total);

    // Scan denominations from largest to smallest, subtracting each coin taken.
    always_comb begin
        coin_mask = '0;
        remaining = total_ext;
        found     = 1'b0;
        for (int k = int'(NUM_COINS) - 1; k >= 0; k--) begin
            if (!found && (remaining >= coin_value[k])) begin
                coin_mask[k] = 1'b1;
                remaining    = remaining - coin_value[k];
`ifndef CHANGE_BATCH_EN
                found        = 1'b1;
`endif
            end
        end
        coin_sum = TOTAL_BITS'(total_ext - remaining);
    end

endmodule

// File: rtl/change_return_controller.sv
// Balance register, inactivity timer and greedy change-return sequencer.
// Optional CHANGE_BATCH_EN (see coin_picker) pays several denominations per cycle.
module change_return_controller
    import change_return_controller_pkg::*;
#(
    parameter int unsigned WAIT_TIME  = kWaitTime,
    parameter int unsigned NUM_COINS  = kNumCoins,
    parameter int unsigned TOTAL_BITS = kTotalBits
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [TOTAL_BITS-1:0]      current_total_nxt,
    input  logic [NUM_COINS-1:0][31:0] coin_value,
    input  logic [NUM_COINS-1:0]       i_input_coin,
    input  logic [kNumItems-1:0]       o_output_item,
    input  logic                       i_trigger_return,
    output logic [TOTAL_BITS-1:0]      current_total,
    output logic [31:0]                wait_time,
    output logic [NUM_COINS-1:0]       o_return_coin,
    output logic                       o_busy
);

    state_e                state_q, state_d;
    logic [TOTAL_BITS-1:0] total_q, total_d;
    logic [31:0]           wait_q, wait_d;
    logic [NUM_COINS-1:0]  ret_q, ret_d;

    logic                  activity;
    logic [NUM_COINS-1:0]  pick_mask;
    logic [TOTAL_BITS-1:0] pick_sum;

    assign activity = (|i_input_coin) || (|o_output_item);

    coin_picker #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_coin_picker (
        .current_total (total_q),
        .coin_value    (coin_value),
        .coin_mask     (pick_mask),
        .coin_sum      (pick_sum)
    );

    // State and datapath registers; reset abandons any refund in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= kStateIdle;
            total_q <= '0;
            wait_q  <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            wait_q  <= wait_d;
            ret_q   <= ret_d;
        end
    end

    // Next-state logic: track the calculator, time out inactivity, then pay back change.
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        wait_d  = wait_q;
        ret_d   = '0;
        unique case (state_q)
            kStateIdle: begin
                total_d = current_total_nxt;
                if (activity) begin
                    wait_d  = 32'(WAIT_TIME);
                    state_d = kStateActive;
                end
                // A return request on an empty balance is ignored.
                if (i_trigger_return && (total_q != '0)) begin
                    wait_d  = '0;
                    state_d = kStateReturn;
                end
            end
            kStateActive: begin
                total_d = current_total_nxt;
                if (activity) begin
                    wait_d = 32'(WAIT_TIME);
                end else if (wait_q != '0) begin
                    wait_d = wait_q - 32'd1;
                end
                if (i_trigger_return || (!activity && (wait_q == 32'd1))) begin
                    wait_d  = '0;
                    state_d = kStateReturn;
                end
            end
            kStateReturn: begin
                if (pick_mask != '0) begin
                    ret_d   = pick_mask;
                    total_d = total_q - pick_sum;
                end else begin
                    // Residue below the smallest coin is dropped.
                    total_d = '0;
                    state_d = kStateIdle;
                end
            end
            default: begin
                total_d = '0;
                wait_d  = '0;
                state_d = kStateIdle;
            end
        endcase
    end

    assign current_total = total_q;
    assign wait_time     = wait_q;
    assign o_return_coin = ret_q;
    assign o_busy        = (state_q == kStateReturn);

endmodule
